// File: rtl/arm7_pkg.sv
// Shared constants and helpers for the ARM7 front end.
package arm7_pkg;
  localparam int WORD_W = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b00;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], WORD_ALIGN_MASK};
  endfunction
endpackage

// File: rtl/arm7_fetch_fifo.sv
// Prefetch FIFO: wrapping pointers, flush, head is zero while empty.
module arm7_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign valid = (count != '0);
  assign head  = valid ? mem[rd_ptr] : '0;

  // The issue throttle upstream must make this unreachable.
  assert property (@(posedge clk) disable iff (reset) !(push && !flush && count == CW'(DEPTH)));
endmodule

// File: rtl/arm7_fetch_unit.sv
// ARM7 instruction fetch: PC, SRAM read issue and prefetch buffer.
// Optional FETCH_PC_TAG_EN adds instr_pc (fetch address of the head word).
module arm7_fetch_unit
  import arm7_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  output logic [WORD_W-1:0] sram_addr,
  output logic              sram_re,
  input  logic [WORD_W-1:0] sram_data_in,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [WORD_W-1:0] instr,
`ifdef FETCH_PC_TAG_EN
  output logic [WORD_W-1:0] instr_pc,
`endif
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;
`ifdef FETCH_PC_TAG_EN
  localparam int FW = 2 * WORD_W;
`else
  localparam int FW = WORD_W;
`endif

  logic [WORD_W-1:0] pc;
  logic              rsp_pending;
  logic [CW-1:0]     count;
  logic [OW-1:0]     occupancy;
  logic              pop;
  logic              push;
  logic              issue;
  logic [FW-1:0]     push_word;
  logic [FW-1:0]     head;

  assign pop  = instr_valid & instr_ready & ~redirect_valid;
  assign push = rsp_pending & ~redirect_valid;

  // Buffered words plus the one in flight, net of this cycle's pop, must leave room.
  assign occupancy = {1'b0, count} + OW'(rsp_pending) - OW'(pop);
  assign issue     = ~reset & ~redirect_valid & (occupancy < OW'(DEPTH));

  assign sram_re   = issue;
  assign sram_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      rsp_pending <= 1'b0;
    end else if (redirect_valid) begin
      pc          <= word_align(redirect_pc);
      rsp_pending <= 1'b0;
    end else begin
      rsp_pending <= issue;
      if (issue) pc <= pc + WORD_W'(INSTR_BYTES);
    end
  end

`ifdef FETCH_PC_TAG_EN
  logic [WORD_W-1:0] pending_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_pc <= '0;
    else if (issue) pending_pc <= pc;
  end

  assign push_word = {pending_pc, sram_data_in};
  assign instr_pc  = head[FW-1:WORD_W];
`else
  assign push_word = sram_data_in;
`endif

  arm7_fetch_fifo #(
    .WIDTH(FW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (push),
    .push_data(push_word),
    .pop      (pop),
    .head     (head),
    .valid    (instr_valid),
    .count    (count)
  );

  assign instr = head[WORD_W-1:0];
endmodule

// File: tb/tb_arm7_fetch_unit.sv
// Self-checking bench for arm7_fetch_unit against a queue-of-fetches model.
module tb_arm7_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] sram_addr;
  logic        sram_re;
  logic [31:0] sram_data_in = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
`ifdef FETCH_PC_TAG_EN
  logic [31:0] instr_pc;
`endif

  always #5 clk = ~clk;

  // SRAM returns its own address as data one cycle after a request, junk otherwise.
  always @(posedge clk) sram_data_in <= sram_re ? sram_addr : $urandom;

  arm7_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .sram_addr     (sram_addr),
    .sram_re       (sram_re),
    .sram_data_in  (sram_data_in),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
`ifdef FETCH_PC_TAG_EN
    .instr_pc      (instr_pc),
`endif
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  int passed = 0;
  int total = 0;

  // Model: addresses fetched since the last flush, oldest first, with issue cycle.
  logic [31:0] qa[$];
  int          qc[$];
  logic [31:0] m_pc;
  int          cyc;
  logic        cur_redir, m_pop;
  logic [31:0] cur_rpc;
  logic        exp_re, exp_valid;
  logic [31:0] exp_addr, exp_instr;

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
    instr_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    cur_redir = rv;
    cur_rpc = rpc;
    #1;
    exp_valid = (qa.size() > 0) && (cyc - qc[0] >= 2);
    exp_instr = exp_valid ? qa[0] : 32'h0;
    m_pop = exp_valid && rdy && !rv;
    exp_re = !rv && ((qa.size() - (m_pop ? 1 : 0)) < DEPTH);
    exp_addr = m_pc;
  endtask

  task automatic advance();
    if (cur_redir) begin
      qa.delete();
      qc.delete();
      m_pc = {cur_rpc[31:2], 2'b00};
    end else begin
      if (m_pop) begin
        void'(qa.pop_front());
        void'(qc.pop_front());
      end
      if (exp_re) begin
        qa.push_back(m_pc);
        qc.push_back(cyc);
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    qa.delete();
    qc.delete();
    m_pc = RESET_PC;
    cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2 reset = 1'b1;
    #2;
    total++;
    if ({sram_re, sram_addr, instr_valid, instr} !== {1'b0, RESET_PC, 1'b0, 32'h0})
      $display("FAIL reset_values got re=%b addr=%h v=%b instr=%h want re=0 addr=%h v=0 instr=0",
               sram_re, sram_addr, instr_valid, instr, RESET_PC);
    else passed++;
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      total++;
      if ({sram_re, sram_addr, instr_valid, instr} !== {exp_re, exp_addr, exp_valid, exp_instr})
        $display("FAIL stream cyc=%0d got re=%b addr=%h v=%b instr=%h want re=%b addr=%h v=%b instr=%h",
                 i, sram_re, sram_addr, instr_valid, instr, exp_re, exp_addr, exp_valid, exp_instr);
      else passed++;
      if (i >= 2) begin
        total++;
        if (instr_valid !== 1'b1 || instr !== 32'(4 * (i - 2)))
          $display("FAIL stream_rate cyc=%0d got v=%b instr=%h want v=1 instr=%h",
                   i, instr_valid, instr, 32'(4 * (i - 2)));
        else passed++;
      end
      advance();
    end
  endtask

  task automatic test_stall();
    int re_cnt = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      if (sram_re) re_cnt++;
      total++;
      if ({sram_re, sram_addr, instr_valid, instr} !== {exp_re, exp_addr, exp_valid, exp_instr})
        $display("FAIL stall cyc=%0d got re=%b addr=%h v=%b instr=%h want re=%b addr=%h v=%b instr=%h",
                 i, sram_re, sram_addr, instr_valid, instr, exp_re, exp_addr, exp_valid, exp_instr);
      else passed++;
      advance();
    end
    total++;
    if (re_cnt !== DEPTH) $display("FAIL stall_requests got %0d want %0d", re_cnt, DEPTH);
    else passed++;
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, 1'b0, 32'h0);
      total++;
      if ({sram_re, sram_addr, instr_valid, instr} !== {exp_re, exp_addr, exp_valid, exp_instr})
        $display("FAIL stall_drain cyc=%0d got re=%b addr=%h v=%b instr=%h want re=%b addr=%h v=%b instr=%h",
                 j, sram_re, sram_addr, instr_valid, instr, exp_re, exp_addr, exp_valid, exp_instr);
      else passed++;
      if (j < 5) begin
        total++;
        if (instr_valid !== 1'b1 || instr !== 32'(4 * j))
          $display("FAIL stall_order j=%0d got v=%b instr=%h want v=1 instr=%h",
                   j, instr_valid, instr, 32'(4 * j));
        else passed++;
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    logic        want_first;
    logic        seen;
    logic [31:0] first_word;
    do_reset();
    want_first = 1'b0;
    seen = 1'b0;
    first_word = 32'h0;
    for (int i = 0; i < 26; i++) begin
      logic rv;
      logic [31:0] rpc;
      rv = (i == 5) || (i == 12) || (i == 18) || (i == 19);
      rpc = (i == 5) ? 32'h100 : (i == 12) ? 32'h203 : (i == 18) ? 32'h40 : 32'h80;
      drive(1'b1, rv, rv ? rpc : 32'h0);
      total++;
      if ({sram_re, sram_addr, instr_valid, instr} !== {exp_re, exp_addr, exp_valid, exp_instr})
        $display("FAIL redirect cyc=%0d got re=%b addr=%h v=%b instr=%h want re=%b addr=%h v=%b instr=%h",
                 i, sram_re, sram_addr, instr_valid, instr, exp_re, exp_addr, exp_valid, exp_instr);
      else passed++;
`ifdef FETCH_PC_TAG_EN
      total++;
      if (instr_pc !== exp_instr) $display("FAIL redirect_tag cyc=%0d got %h want %h", i, instr_pc, exp_instr);
      else passed++;
`endif
      if (i == 6) begin
        total++;
        if (sram_re !== 1'b1 || sram_addr !== 32'h100 || instr_valid !== 1'b0)
          $display("FAIL redirect_target got re=%b addr=%h v=%b want re=1 addr=00000100 v=0",
                   sram_re, sram_addr, instr_valid);
        else passed++;
      end
      if (i == 8 || i == 15) begin
        total++;
        if (instr_valid !== 1'b1 || instr !== ((i == 8) ? 32'h100 : 32'h200))
          $display("FAIL redirect_first cyc=%0d got v=%b instr=%h", i, instr_valid, instr);
        else passed++;
      end
      if (i == 19) want_first = 1'b1;
      else if (want_first && !seen && instr_valid && instr_ready) begin
        seen = 1'b1;
        first_word = instr;
      end
      advance();
    end
    total++;
    if (!seen || first_word !== 32'h80)
      $display("FAIL double_redirect got seen=%b word=%h want word=00000080", seen, first_word);
    else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i == 1, 32'hFFFF_FFFE);
      total++;
      if ({sram_re, sram_addr, instr_valid, instr} !== {exp_re, exp_addr, exp_valid, exp_instr})
        $display("FAIL wrap cyc=%0d got re=%b addr=%h v=%b instr=%h want re=%b addr=%h v=%b instr=%h",
                 i, sram_re, sram_addr, instr_valid, instr, exp_re, exp_addr, exp_valid, exp_instr);
      else passed++;
      if (i == 3) begin
        total++;
        if (sram_addr !== 32'h0) $display("FAIL wrap_addr got %h want 00000000", sram_addr);
        else passed++;
      end
      if (i == 4) begin
        total++;
        if (instr_valid !== 1'b1 || instr !== 32'hFFFF_FFFC)
          $display("FAIL wrap_word got v=%b instr=%h want v=1 instr=fffffffc", instr_valid, instr);
        else passed++;
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      advance();
    end
    drive(1'b0, 1'b0, 32'h0);
    total++;
    if (qa.size() !== 4 || instr_valid !== 1'b1)
      $display("FAIL pre_reset_fill got v=%b model=%0d want v=1 model=4", instr_valid, qa.size());
    else passed++;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({sram_re, sram_addr, instr_valid, instr} !== {1'b0, RESET_PC, 1'b0, 32'h0})
      $display("FAIL reset_mid got re=%b addr=%h v=%b instr=%h want re=0 addr=%h v=0 instr=0",
               sram_re, sram_addr, instr_valid, instr, RESET_PC);
    else passed++;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      total++;
      if ({sram_re, sram_addr, instr_valid, instr} !== {exp_re, exp_addr, exp_valid, exp_instr})
        $display("FAIL after_reset cyc=%0d got re=%b addr=%h v=%b instr=%h want re=%b addr=%h v=%b instr=%h",
                 i, sram_re, sram_addr, instr_valid, instr, exp_re, exp_addr, exp_valid, exp_instr);
      else passed++;
      advance();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);
      total++;
      if ({sram_re, sram_addr, instr_valid, instr} !== {exp_re, exp_addr, exp_valid, exp_instr})
        $display("FAIL random cyc=%0d got re=%b addr=%h v=%b instr=%h want re=%b addr=%h v=%b instr=%h",
                 i, sram_re, sram_addr, instr_valid, instr, exp_re, exp_addr, exp_valid, exp_instr);
      else passed++;
`ifdef FETCH_PC_TAG_EN
      total++;
      if (instr_pc !== exp_instr) $display("FAIL random_tag cyc=%0d got %h want %h", i, instr_pc, exp_instr);
      else passed++;
`endif
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
